// File: rtl/ysyx_24120013_pkg.sv
// Shared definitions for the NPC instruction sequencer: FSM encoding, halt causes,
// and the stop-condition decode used in EXEC.
package ysyx_24120013_pkg;

   localparam int unsigned STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_FETCH = 3'd1;
   localparam state_t S_WAIT  = 3'd2;
   localparam state_t S_EXEC  = 3'd3;
   localparam state_t S_WB    = 3'd4;
   localparam state_t S_HALT  = 3'd5;

   typedef logic [1:0] halt_code_t;
   localparam halt_code_t HALT_EBREAK   = 2'd0;
   localparam halt_code_t HALT_ILLEGAL  = 2'd1;
   localparam halt_code_t HALT_MISALIGN = 2'd2;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

   typedef struct packed {
      logic       stop;    // leave the fetch loop for HALT
      logic       retire;  // the stopping instruction still counts as retired
      halt_code_t code;
   } stop_t;

   // Priority: illegal > ebreak > misaligned next PC.
   function automatic stop_t stop_decode(input logic       illegal,
                                         input logic       ebreak,
                                         input logic [1:0] dnpc_lsb);
      stop_t s;
      s = '{stop: 1'b0, retire: 1'b0, code: HALT_EBREAK};
      if (illegal) begin
         s = '{stop: 1'b1, retire: 1'b0, code: HALT_ILLEGAL};
      end else if (ebreak) begin
         s = '{stop: 1'b1, retire: 1'b1, code: HALT_EBREAK};
      end else if (dnpc_lsb != 2'b00) begin
         s = '{stop: 1'b1, retire: 1'b0, code: HALT_MISALIGN};
      end
      return s;
   endfunction

endpackage

// File: rtl/ysyx_24120013_ctrl_if.sv
// Instruction-fetch port: valid/ready request toward memory, valid-only response back.
interface ysyx_24120013_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_ready;
   logic                  rsp_valid;
   logic [31:0]           rsp_inst;

   modport master (
      output req_valid, req_addr,
      input  req_ready, rsp_valid, rsp_inst
   );

   modport slave (
      input  req_valid, req_addr,
      output req_ready, rsp_valid, rsp_inst
   );
endinterface

// File: rtl/ysyx_24120013_perf_cnt.sv
// Free-running 64-bit cycle and retired-instruction counters; both wrap modulo 2^64.
module ysyx_24120013_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_cycle,
   input  logic        inc_instret,
   output logic [63:0] cycle_cnt,
   output logic [63:0] instret_cnt
);

   logic [63:0] cycle_q, cycle_d;
   logic [63:0] instret_q, instret_d;

   always_comb begin
      cycle_d   = cycle_q + 64'(inc_cycle);
      instret_d = instret_q + 64'(inc_instret);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end

   assign cycle_cnt   = cycle_q;
   assign instret_cnt = instret_q;

endmodule

// File: rtl/ysyx_24120013_ctrl.sv
// Multi-cycle sequencer: FETCH -> WAIT -> EXEC -> WB per instruction, owns the PC,
// the latched instruction, the register-file write strobe and the halt status.
module ysyx_24120013_ctrl
   import ysyx_24120013_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  rst,

   ysyx_24120013_ctrl_if.master  ifu,

   output logic [31:0]           inst,
   output logic                  inst_valid,

   input  logic                  exu_wen,
   input  logic [4:0]            exu_waddr,
   input  logic [DATA_WIDTH-1:0] exu_wdata,
   input  logic [ADDR_WIDTH-1:0] exu_dnpc,
   input  logic                  idu_ebreak,
   input  logic                  idu_illegal,

   output logic                  rf_wen,
   output logic [4:0]            rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,

   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  halt,
   output logic [1:0]            halt_code,
   output logic [63:0]           cycle_cnt,
   output logic [63:0]           instret_cnt
);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] dnpc_q, dnpc_d;
   logic [31:0]           inst_q, inst_d;
   logic                  rf_wen_q, rf_wen_d;
   logic [4:0]            rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
   logic                  halt_q, halt_d;
   halt_code_t            halt_code_q, halt_code_d;

   stop_t                 exec_stop;
   logic                  fetch_fire;
   logic                  inc_instret;

   assign exec_stop  = stop_decode(idu_illegal, idu_ebreak, exu_dnpc[1:0]);
   assign fetch_fire = (state_q == S_FETCH) && ifu.req_ready;

   // ---------------- FSM: state register ----------------
   // NOTE: sequential state is updated only with non-blocking assignments so every
   // flop samples the pre-edge values of the others, independent of process order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   // NOTE: every always_comb output gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: if (fetch_fire)    state_d = S_WAIT;
         S_WAIT:  if (ifu.rsp_valid) state_d = S_EXEC;
         S_EXEC:  state_d = exec_stop.stop ? S_HALT : S_WB;
         S_WB:    state_d = S_FETCH;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: state-decoded outputs ----------------
   always_comb begin
      ifu.req_valid = (state_q == S_FETCH);
      ifu.req_addr  = pc_q;
      inst_valid    = (state_q == S_EXEC);
   end

   // ---------------- datapath next values ----------------
   always_comb begin
      pc_d        = pc_q;
      dnpc_d      = dnpc_q;
      inst_d      = inst_q;
      rf_wen_d    = 1'b0;
      rf_waddr_d  = rf_waddr_q;
      rf_wdata_d  = rf_wdata_q;
      halt_d      = halt_q;
      halt_code_d = halt_code_q;
      unique case (state_q)
         S_WAIT: begin
            if (ifu.rsp_valid) inst_d = ifu.rsp_inst;
         end
         S_EXEC: begin
            if (exec_stop.stop) begin
               halt_d      = 1'b1;
               halt_code_d = exec_stop.code;
            end else begin
               dnpc_d     = exu_dnpc;
               rf_wen_d   = exu_wen && (exu_waddr != 5'd0);
               rf_waddr_d = exu_waddr;
               rf_wdata_d = exu_wdata;
            end
         end
         S_WB:    pc_d = dnpc_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         dnpc_q      <= RESET_PC;
         inst_q      <= '0;
         rf_wen_q    <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
         halt_q      <= 1'b0;
         halt_code_q <= HALT_EBREAK;
      end else begin
         pc_q        <= pc_d;
         dnpc_q      <= dnpc_d;
         inst_q      <= inst_d;
         rf_wen_q    <= rf_wen_d;
         rf_waddr_q  <= rf_waddr_d;
         rf_wdata_q  <= rf_wdata_d;
         halt_q      <= halt_d;
         halt_code_q <= halt_code_d;
      end
   end

   // ebreak retires on its way into HALT; illegal and misaligned stops do not.
   assign inc_instret = (state_q == S_WB) || ((state_q == S_EXEC) && exec_stop.retire);

   ysyx_24120013_perf_cnt u_perf_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc_cycle   (1'b1),
      .inc_instret (inc_instret),
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
   );

   assign inst      = inst_q;
   // A WB write coinciding with reset must not reach the register file.
   assign rf_wen    = rf_wen_q && !rst;
   assign rf_waddr  = rf_waddr_q;
   assign rf_wdata  = rf_wdata_q;
   assign pc        = pc_q;
   assign halt      = halt_q;
   assign halt_code = halt_code_q;

endmodule
